ct_mmu_jtlb_data_array_ctrl: RTL and testbench

Parametrised successor to the two-bank JTLB data array. It provides WAYS single-port banks, each DEPTH x DATA_W, with segmented write enables and registered per-way read data with valid flags. A hardware init/invalidate-all sweep zeroes every entry after reset or on request. It sits between the JTLB control logic and the data SRAMs, under one gated clock derived from forever_cpuclk.

---
 rtl/ct_mmu_jtlb_pkg.sv | 33 +++
 rtl/ct_mmu_jtlb_data_array_ctrl_if.sv | 38 +++
 rtl/ct_mmu_jtlb_data_bank.sv | 42 ++++
 rtl/gated_clk_cell.sv | 22 ++
 rtl/ct_mmu_jtlb_data_array_ctrl.sv | 128 ++++++++++++
 tb/tb_ct_mmu_jtlb_data_array_ctrl.sv | 297 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ct_mmu_jtlb_pkg.sv
// Shared types, default geometry and the segment-mask helper for the JTLB data array.
package ct_mmu_jtlb_pkg;

    localparam int unsigned DEF_WAYS   = 2;
    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned DEF_DATA_W = 84;
    localparam int unsigned DEF_SEG    = 2;

    localparam int unsigned MAX_DATA_W = 1024;
    localparam int unsigned MAX_SEG    = 64;
    localparam int unsigned MASK_IW    = $clog2(MAX_DATA_W);
    localparam int unsigned SEG_IW     = $clog2(MAX_SEG);

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } jtlb_state_e;

    // Expand one enable bit per segment into a per-bit mask over data_w bits.
    function automatic logic [MAX_DATA_W-1:0] seg_mask(input logic [MAX_SEG-1:0] wen_seg,
                                                       input int unsigned data_w,
                                                       input int unsigned seg);
        logic [MAX_DATA_W-1:0] mask;
        int unsigned seg_w;
        mask  = '0;
        seg_w = data_w / seg;
        for (int unsigned b = 0; b < MAX_DATA_W; b++) begin
            if (b < data_w) mask[MASK_IW'(b)] = wen_seg[SEG_IW'(b / seg_w)];
        end
        return mask;
    endfunction

endpackage

// File: rtl/ct_mmu_jtlb_data_array_ctrl_if.sv
// Request/response bundle between the JTLB control logic and the data array controller.
interface ct_mmu_jtlb_data_array_ctrl_if
    import ct_mmu_jtlb_pkg::*;
#(
    parameter int unsigned WAYS   = DEF_WAYS,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SEG    = DEF_SEG
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic                     jtlb_data_req;
    logic [WAYS-1:0]          jtlb_data_cen;
    logic [WAYS*SEG-1:0]      jtlb_data_wen;
    logic [IDX_W-1:0]         jtlb_data_idx;
    logic [DATA_W-1:0]        jtlb_data_din;
    logic                     jtlb_data_inv_all;
    logic                     jtlb_data_ready;
    logic                     jtlb_data_busy;
    logic                     jtlb_data_init_done;
    logic [WAYS*DATA_W-1:0]   jtlb_data_dout;
    logic [WAYS-1:0]          jtlb_data_dout_vld;

    modport master (
        output jtlb_data_req, jtlb_data_cen, jtlb_data_wen, jtlb_data_idx,
               jtlb_data_din, jtlb_data_inv_all,
        input  jtlb_data_ready, jtlb_data_busy, jtlb_data_init_done,
               jtlb_data_dout, jtlb_data_dout_vld
    );

    modport slave (
        input  jtlb_data_req, jtlb_data_cen, jtlb_data_wen, jtlb_data_idx,
               jtlb_data_din, jtlb_data_inv_all,
        output jtlb_data_ready, jtlb_data_busy, jtlb_data_init_done,
               jtlb_data_dout, jtlb_data_dout_vld
    );

endinterface

// File: rtl/ct_mmu_jtlb_data_bank.sv
// One single-port bank: segmented write, one-cycle registered read data.
module ct_mmu_jtlb_data_bank
    import ct_mmu_jtlb_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned SEG    = DEF_SEG,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [SEG-1:0]    wen,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mask_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    always_comb begin
        mask_c    = DATA_W'(seg_mask(MAX_SEG'(wen), DATA_W, SEG));
        wr_data_c = (mem_q[idx] & ~mask_c) | (din & mask_c);
        q_d       = cen ? mem_q[idx] : q_q;
    end

    // Storage array carries no reset; the init sweep clears it.
    always_ff @(posedge clk) begin
        if (|wen) mem_q[idx] <= wr_data_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate: enable sampled while the clock is low.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    logic clk_en_c;
    logic en_lat;

    assign clk_en_c = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in) en_lat <= clk_en_c | pad_yy_icg_scan_en;
    end

    assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/ct_mmu_jtlb_data_array_ctrl.sv
// JTLB data array controller: init/invalidate sweep FSM, request steering to WAYS banks,
// registered read-valid flags, all under one gated clock.
module ct_mmu_jtlb_data_array_ctrl
    import ct_mmu_jtlb_pkg::*;
#(
    parameter int unsigned WAYS   = DEF_WAYS,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SEG    = DEF_SEG
) (
    input  logic                              forever_cpuclk,
    input  logic                              cpurst_b,
    input  logic                              cp0_mmu_icg_en,
    input  logic                              pad_yy_icg_scan_en,
    ct_mmu_jtlb_data_array_ctrl_if.slave      bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    jtlb_state_e            state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic                   init_done_q, init_done_d;
    logic [WAYS-1:0]        dout_vld_q, dout_vld_d;

    logic                   gclk;
    logic                   local_en_c;
    logic                   busy_c;
    logic [WAYS-1:0]        way_wr_c;
    logic [WAYS-1:0]        bank_cen_c;
    logic [WAYS*SEG-1:0]    bank_wen_c;
    logic [IDX_W-1:0]       bank_idx_c;
    logic [DATA_W-1:0]      bank_din_c;
    logic [WAYS*DATA_W-1:0] dout_c;

    assign busy_c = (state_q == INIT);

    // init_done_q keeps the clock alive one more edge so the pulse can drop.
    assign local_en_c = busy_c | bus.jtlb_data_inv_all
                      | (bus.jtlb_data_req & ((|bus.jtlb_data_cen) | (|bus.jtlb_data_wen)))
                      | (|dout_vld_q) | init_done_q;

    gated_clk_cell u_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (cp0_mmu_icg_en),
        .local_en           (local_en_c),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (gclk)
    );

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_wr_c[w] = |bus.jtlb_data_wen[w*SEG +: SEG];

        ct_mmu_jtlb_data_bank #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .SEG    (SEG)
        ) u_bank (
            .clk   (gclk),
            .rst_n (cpurst_b),
            .cen   (bank_cen_c[w]),
            .wen   (bank_wen_c[w*SEG +: SEG]),
            .idx   (bank_idx_c),
            .din   (bank_din_c),
            .q     (dout_c[w*DATA_W +: DATA_W])
        );
    end

    // Sweep/idle control and per-way steering; a writing way never reads.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = 1'b0;
        dout_vld_d  = '0;
        bank_cen_c  = '0;
        bank_wen_c  = '0;
        bank_idx_c  = bus.jtlb_data_idx;
        bank_din_c  = bus.jtlb_data_din;
        case (state_q)
            INIT: begin
                bank_wen_c = '1;
                bank_idx_c = cnt_q;
                bank_din_c = '0;
                if (bus.jtlb_data_inv_all) begin
                    cnt_d = '0;
                end else if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            IDLE: begin
                if (bus.jtlb_data_inv_all) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (bus.jtlb_data_req) begin
                    bank_wen_c = bus.jtlb_data_wen;
                    bank_cen_c = bus.jtlb_data_cen & ~way_wr_c;
                    dout_vld_d = bus.jtlb_data_cen & ~way_wr_c;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge gclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            dout_vld_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    assign bus.jtlb_data_ready     = (state_q == IDLE) && !bus.jtlb_data_inv_all;
    assign bus.jtlb_data_busy      = busy_c;
    assign bus.jtlb_data_init_done = init_done_q;
    assign bus.jtlb_data_dout_vld  = dout_vld_q;
    assign bus.jtlb_data_dout      = dout_c;

endmodule

// File: tb/tb_ct_mmu_jtlb_data_array_ctrl.sv
// Bench for ct_mmu_jtlb_data_array_ctrl: directed scenarios plus random traffic against a
// behavioural array model, and a second instance with four ways / 64 entries / four segments.
module tb_ct_mmu_jtlb_data_array_ctrl;

    localparam int unsigned W  = 2;
    localparam int unsigned D  = 256;
    localparam int unsigned DW = 84;
    localparam int unsigned S  = 2;
    localparam int unsigned IW = 8;
    localparam int unsigned SW = DW / S;

    localparam int unsigned W2 = 4;
    localparam int unsigned D2 = 64;
    localparam int unsigned S2 = 4;

    logic clk;
    logic rst_n;
    logic rst2_n;
    logic icg_en;
    logic scan_en;

    int n_chk;
    int n_fail;

    ct_mmu_jtlb_data_array_ctrl_if #(.WAYS(W), .DEPTH(D), .DATA_W(DW), .SEG(S)) bus ();
    ct_mmu_jtlb_data_array_ctrl_if #(.WAYS(W2), .DEPTH(D2), .DATA_W(DW), .SEG(S2)) bus2 ();

    ct_mmu_jtlb_data_array_ctrl #(.WAYS(W), .DEPTH(D), .DATA_W(DW), .SEG(S)) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_n),
        .cp0_mmu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .bus                (bus.slave)
    );

    ct_mmu_jtlb_data_array_ctrl #(.WAYS(W2), .DEPTH(D2), .DATA_W(DW), .SEG(S2)) dut2 (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst2_n),
        .cp0_mmu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .bus                (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: array contents, last read data per way, and cycles left in a sweep.
    logic [DW-1:0] m_mem  [W][D];
    logic [DW-1:0] m_dout [W];
    logic [W-1:0]  m_vld;
    logic          m_done;
    int            m_left;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] seg_bits(input logic [S-1:0] ws);
        logic [DW-1:0] m;
        m = '0;
        for (int s = 0; s < int'(S); s++) if (ws[s]) m[s*SW +: SW] = '1;
        return m;
    endfunction

    function automatic logic [DW-1:0] rnd_din();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    function automatic logic [W*S-1:0] rnd_wen();
        logic [W*S-1:0] v;
        v = '0;
        for (int w = 0; w < int'(W); w++) if ($urandom_range(2) == 0) v[w*S +: S] = S'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        m_left = D;
        m_vld  = '0;
        m_done = 1'b0;
        for (int w = 0; w < int'(W); w++) m_dout[w] = '0;
    endtask

    task automatic model_step();
        logic [S-1:0]  ws;
        logic [DW-1:0] mk;
        m_vld  = '0;
        m_done = 1'b0;
        if (m_left > 0) begin
            if (bus.jtlb_data_inv_all) m_left = D;
            else begin
                m_left--;
                if (m_left == 0) begin
                    for (int w = 0; w < int'(W); w++)
                        for (int i = 0; i < int'(D); i++) m_mem[w][i] = '0;
                    m_done = 1'b1;
                end
            end
        end else if (bus.jtlb_data_inv_all) begin
            m_left = D;
        end else if (bus.jtlb_data_req) begin
            for (int w = 0; w < int'(W); w++) begin
                ws = bus.jtlb_data_wen[w*S +: S];
                if (ws != '0) begin
                    mk = seg_bits(ws);
                    m_mem[w][bus.jtlb_data_idx] = (m_mem[w][bus.jtlb_data_idx] & ~mk)
                                                | (bus.jtlb_data_din & mk);
                end else if (bus.jtlb_data_cen[w]) begin
                    m_dout[w] = m_mem[w][bus.jtlb_data_idx];
                    m_vld[w]  = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [W*DW-1:0] e;
        for (int w = 0; w < int'(W); w++) e[w*DW +: DW] = m_dout[w];
        chk("busy",      512'(bus.jtlb_data_busy),      512'(m_left > 0));
        chk("init_done", 512'(bus.jtlb_data_init_done), 512'(m_done));
        chk("dout_vld",  512'(bus.jtlb_data_dout_vld),  512'(m_vld));
        chk("dout",      512'(bus.jtlb_data_dout),      512'(e));
    endtask

    // One clock: drive, check ready, advance model, check registered outputs.
    task automatic cyc(input logic req, input logic [W-1:0] cen, input logic [W*S-1:0] wen,
                       input logic [IW-1:0] idx, input logic [DW-1:0] din, input logic inv);
        bus.jtlb_data_req     = req;
        bus.jtlb_data_cen     = cen;
        bus.jtlb_data_wen     = wen;
        bus.jtlb_data_idx     = idx;
        bus.jtlb_data_din     = din;
        bus.jtlb_data_inv_all = inv;
        #1;
        chk("ready", 512'(bus.jtlb_data_ready), 512'((m_left == 0) && !inv));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic rnd_cyc(input logic inv);
        cyc($urandom_range(3) != 0, W'($urandom), rnd_wen(), IW'($urandom_range(15)), rnd_din(), inv);
    endtask

    task automatic sweep(input int inv_at, input int exp_len, input string nm);
        int n;
        n = 0;
        while (n < 2000) begin
            n++;
            rnd_cyc(n == inv_at);
            if (bus.jtlb_data_init_done) break;
        end
        chk(nm, 512'(n), 512'(exp_len));
    endtask

    task automatic do_reset();
        bus.jtlb_data_req     = 1'b0;
        bus.jtlb_data_cen     = '0;
        bus.jtlb_data_wen     = '0;
        bus.jtlb_data_inv_all = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst dout",  512'(bus.jtlb_data_dout),      512'(0));
        chk("rst vld",   512'(bus.jtlb_data_dout_vld),  512'(0));
        chk("rst busy",  512'(bus.jtlb_data_busy),      512'(1));
        chk("rst ready", 512'(bus.jtlb_data_ready),     512'(0));
        chk("rst done",  512'(bus.jtlb_data_init_done), 512'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DW-1:0] ones;
        n_chk   = 0;
        n_fail  = 0;
        ones    = '1;
        icg_en  = 1'b0;
        scan_en = 1'b0;
        rst_n   = 1'b1;
        rst2_n  = 1'b0;
        bus.jtlb_data_idx  = '0;
        bus.jtlb_data_din  = '0;
        bus2.jtlb_data_req = 1'b0;
        bus2.jtlb_data_cen = '0;
        bus2.jtlb_data_wen = '0;
        bus2.jtlb_data_idx = '0;
        bus2.jtlb_data_din = '0;
        bus2.jtlb_data_inv_all = 1'b0;
        #2;
        do_reset();

        // Power-up sweep, then every way reads zero.
        sweep(0, 256, "t1 sweep len");
        cyc(1'b1, 2'b11, 4'b0000, 8'h7F, rnd_din(), 1'b0);
        chk("t1 vld",  512'(bus.jtlb_data_dout_vld), 512'(2'b11));
        chk("t1 dout", 512'(bus.jtlb_data_dout),     512'(0));

        // Segmented write on way1 and read-back.
        cyc(1'b1, 2'b00, 4'b1100, 8'h12, ones, 1'b0);
        cyc(1'b1, 2'b10, 4'b0000, 8'h12, rnd_din(), 1'b0);
        chk("t2 vld",     512'(bus.jtlb_data_dout_vld),       512'(2'b10));
        chk("t2 w1 ones", 512'(bus.jtlb_data_dout[DW +: DW]), 512'(ones));
        cyc(1'b1, 2'b00, 4'b0100, 8'h12, '0, 1'b0);
        cyc(1'b1, 2'b10, 4'b0000, 8'h12, rnd_din(), 1'b0);
        chk("t2 w1 seg0 cleared", 512'(bus.jtlb_data_dout[DW +: DW]),
            512'({{42{1'b1}}, {42{1'b0}}}));

        // cen and wen together on way0: write wins, way0 dout holds.
        cyc(1'b1, 2'b00, 4'b0011, 8'h05, ones, 1'b0);
        cyc(1'b1, 2'b01, 4'b0000, 8'h05, rnd_din(), 1'b0);
        cyc(1'b1, 2'b11, 4'b0011, 8'h05, '0, 1'b0);
        chk("t3 vld",     512'(bus.jtlb_data_dout_vld),  512'(2'b10));
        chk("t3 w0 hold", 512'(bus.jtlb_data_dout[0 +: DW]), 512'(ones));
        cyc(1'b1, 2'b01, 4'b0000, 8'h05, rnd_din(), 1'b0);
        chk("t3 w0 new",  512'(bus.jtlb_data_dout[0 +: DW]), 512'(0));

        // Invalidate, then restart the sweep 100 cycles in.
        cyc(1'b0, '0, '0, '0, '0, 1'b1);
        sweep(101, 357, "t4 restart len");

        // Request coinciding with inv_all is dropped; entry ends up zero.
        cyc(1'b1, 2'b00, 4'b0011, 8'h33, ones, 1'b0);
        cyc(1'b1, 2'b00, 4'b0011, 8'h33, ones, 1'b1);
        sweep(0, 256, "t5 sweep len");
        cyc(1'b1, 2'b01, 4'b0000, 8'h33, rnd_din(), 1'b0);
        chk("t5 cleared", 512'(bus.jtlb_data_dout[0 +: DW]), 512'(0));

        // Random traffic with an occasional inv_all and one mid-read reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) icg_en = 1'b1;
            if (i == 1000) begin
                cyc(1'b1, 2'b11, 4'b0000, IW'($urandom_range(15)), rnd_din(), 1'b0);
                do_reset();
                sweep(0, 256, "t6 sweep len");
            end
            rnd_cyc($urandom_range(399) == 0);
        end
        cyc(1'b0, '0, '0, '0, '0, 1'b0);

        // Four ways, 64 entries, four segments.
        rst2_n = 1'b1;
        n = 0;
        while (n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (bus2.jtlb_data_init_done) break;
        end
        chk("i2 sweep len", 512'(n), 512'(64));
        chk("i2 busy",      512'(bus2.jtlb_data_busy), 512'(0));
        bus2.jtlb_data_req = 1'b1;
        bus2.jtlb_data_cen = 4'hF;
        bus2.jtlb_data_idx = 6'h3F;
        @(posedge clk);
        #1;
        chk("i2 read vld",  512'(bus2.jtlb_data_dout_vld), 512'(4'hF));
        chk("i2 read zero", 512'(bus2.jtlb_data_dout),     512'(0));
        bus2.jtlb_data_cen = 4'h0;
        bus2.jtlb_data_wen = 16'h0A00;
        bus2.jtlb_data_idx = 6'd3;
        bus2.jtlb_data_din = ones;
        @(posedge clk);
        #1;
        chk("i2 write vld", 512'(bus2.jtlb_data_dout_vld), 512'(0));
        bus2.jtlb_data_wen = '0;
        bus2.jtlb_data_cen = 4'b1100;
        @(posedge clk);
        #1;
        chk("i2 vld",     512'(bus2.jtlb_data_dout_vld), 512'(4'b1100));
        chk("i2 w2 segs", 512'(bus2.jtlb_data_dout[2*DW +: DW]),
            512'({{21{1'b1}}, {21{1'b0}}, {21{1'b1}}, {21{1'b0}}}));
        chk("i2 w3 zero", 512'(bus2.jtlb_data_dout[3*DW +: DW]), 512'(0));
        bus2.jtlb_data_req = 1'b0;
        @(posedge clk);
        #1;
        chk("i2 vld drop", 512'(bus2.jtlb_data_dout_vld), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
